// File: rtl/input_conditioner_pkg.sv
// Shared constants and types for the button input conditioner.
package input_conditioner_pkg;

  localparam int unsigned NUM_BUTTONS = 7;
  localparam int unsigned NUM_DIRS    = 4;

  // Button bit positions on raw_buttons / held / pulse buses.
  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;
  localparam int unsigned BTN_A     = 4;
  localparam int unsigned BTN_B     = 5;
  localparam int unsigned BTN_START = 6;

  // Auto-repeat state for each direction button.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDelay  = 2'd1,
    StRepeat = 2'd2
  } rpt_state_e;

  // Counter width able to hold limit-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button: synchroniser, debounce counter, held level and edge pulses.
module debounce_cell
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic held,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned     CntW    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q;
  logic            level_q;
  logic            held_q;
  logic            press_q;
  logic            release_q;
  logic            raw_pressed;
  logic            differs;

  // Polarity is fixed before the synchroniser so that cleared flops read as released;
  // otherwise an active-low pin would look pressed for two cycles after reset.
  assign raw_pressed = ACTIVE_LOW ? ~raw : raw;
  assign differs     = sync_q[1] ^ level_q;

  // Two-flop synchroniser on the normalised pin.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], raw_pressed};
    end
  end

  // Count consecutive disagreeing cycles; flip the level once the run is long enough.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (!differs) begin
      cnt_q <= '0;
    end else if (cnt_q >= CntLast) begin
      level_q <= ~level_q;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Registered held output with press/release pulses aligned to its edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      held_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      held_q    <= level_q;
      press_q   <= level_q & ~held_q;
      release_q <= ~level_q & held_q;
    end
  end

  assign level         = level_q;
  assign held          = held_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: rtl/input_conditioner.sv
// Debounces seven buttons and adds auto-repeat move events on the four directions.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_RATE     = 6_250_000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] raw_buttons,
  output logic [NUM_BUTTONS-1:0] held,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse,
  output logic [NUM_DIRS-1:0]    move_pulse
);

  localparam int unsigned RptLimit = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RptW     = cnt_width(RptLimit);
  // The counter is 0 on the edge after the press pulse, so the first repeat lands
  // REPEAT_DELAY edges after the press when it holds REPEAT_DELAY-2. Needs REPEAT_DELAY >= 2.
  localparam logic [RptW-1:0] DelayLast = RptW'(REPEAT_DELAY - 2);
  localparam logic [RptW-1:0] RateLast  = RptW'(REPEAT_RATE - 1);

  logic [NUM_BUTTONS-1:0] level;
  logic [NUM_DIRS-1:0]    repeat_pulse;
  logic                   unused_level;

  for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_btn
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_cell (
      .clk          (clk),
      .reset        (reset),
      .raw          (raw_buttons[b]),
      .level        (level[b]),
      .held         (held[b]),
      .press_pulse  (press_pulse[b]),
      .release_pulse(release_pulse[b])
    );
  end

  for (genvar d = 0; d < NUM_DIRS; d++) begin : g_dir
    rpt_state_e      state_q;
    logic [RptW-1:0] cnt_q;
    logic            rep_q;

    // Auto-repeat FSM; aborts on the internal level so no pulse coincides with held falling.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        rep_q   <= 1'b0;
      end else begin
        rep_q <= 1'b0;
        unique case (state_q)
          StIdle: begin
            if (press_pulse[d]) begin
              state_q <= StDelay;
              cnt_q   <= '0;
            end
          end
          StDelay: begin
            if (!level[d]) begin
              state_q <= StIdle;
            end else if (cnt_q >= DelayLast) begin
              state_q <= StRepeat;
              cnt_q   <= '0;
              rep_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StRepeat: begin
            if (!level[d]) begin
              state_q <= StIdle;
            end else if (cnt_q >= RateLast) begin
              cnt_q <= '0;
              rep_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign repeat_pulse[d] = rep_q;
  end

  assign move_pulse   = press_pulse[NUM_DIRS-1:0] | repeat_pulse;
  // a, b and start have no auto-repeat, so their internal levels go nowhere.
  assign unused_level = ^level[BTN_START:NUM_DIRS];

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench: directed scenarios plus random pin activity against an
// edge-indexed reference model of debounce, pulses and auto-repeat.
module tb_input_conditioner;

  localparam int D    = 4;
  localparam int RD   = 10;
  localparam int RR   = 3;
  localparam int NB   = 7;
  localparam int ND   = 4;
  localparam int HIST = 4096;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] raw_buttons;
  logic [NB-1:0] held;
  logic [NB-1:0] press_pulse;
  logic [NB-1:0] release_pulse;
  logic [ND-1:0] move_pulse;

  input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .raw_buttons  (raw_buttons),
    .held         (held),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .move_pulse   (move_pulse)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model state. ep counts edges since reset was last sampled high (first sampling edge = 0).
  int ep;
  bit smp       [NB][HIST];
  bit lvl       [NB];
  int commit_t  [NB];
  bit held_m    [NB];
  int toggle_at [NB];
  int rise_t    [NB];
  bit exp_press [NB];
  bit exp_rel   [NB];

  // A level change is accepted once D consecutive samples (all taken after the previous
  // change) disagree with it; held and the pulse appear 3 edges after the last such sample,
  // i.e. D+2 edges after the first.
  task automatic model_edge(input logic rst, input logic [NB-1:0] raw);
    bit stable;
    if (rst) begin
      ep = -1;
      for (int b = 0; b < NB; b++) begin
        lvl[b]       = 1'b0;
        commit_t[b]  = -1;
        held_m[b]    = 1'b0;
        toggle_at[b] = -1;
        rise_t[b]    = -100000;
        exp_press[b] = 1'b0;
        exp_rel[b]   = 1'b0;
      end
    end else begin
      ep++;
      for (int b = 0; b < NB; b++) begin
        exp_press[b] = 1'b0;
        exp_rel[b]   = 1'b0;
        smp[b][ep]   = ~raw[b];
        if (toggle_at[b] == ep) begin
          held_m[b] = ~held_m[b];
          if (held_m[b]) begin
            exp_press[b] = 1'b1;
            rise_t[b]    = ep;
          end else begin
            exp_rel[b] = 1'b1;
          end
          toggle_at[b] = -1;
        end
        if (ep - commit_t[b] >= D) begin
          stable = 1'b1;
          for (int k = ep - D + 1; k <= ep; k++) begin
            if (smp[b][k] == lvl[b]) stable = 1'b0;
          end
          if (stable) begin
            lvl[b]       = ~lvl[b];
            commit_t[b]  = ep;
            toggle_at[b] = ep + 3;
          end
        end
      end
    end
  endtask

  // Move event: the press itself, then RD edges later, then every RR edges while held.
  function automatic bit exp_move(input int b);
    int dt;
    dt = ep - rise_t[b];
    if (exp_press[b]) return 1'b1;
    if (!held_m[b]) return 1'b0;
    return (dt == RD) || (dt > RD && ((dt - RD) % RR) == 0);
  endfunction

  task automatic check();
    logic [NB-1:0] e_held;
    logic [NB-1:0] e_prs;
    logic [NB-1:0] e_rel;
    logic [ND-1:0] e_mov;
    for (int b = 0; b < NB; b++) begin
      e_held[b] = held_m[b];
      e_prs[b]  = exp_press[b];
      e_rel[b]  = exp_rel[b];
    end
    for (int b = 0; b < ND; b++) e_mov[b] = exp_move(b);
    vectors++;
    assert (held === e_held) else begin
      miscompares++;
      $error("FAIL held edge=%0d got=%b want=%b", ep, held, e_held);
    end
    vectors++;
    assert (press_pulse === e_prs) else begin
      miscompares++;
      $error("FAIL press_pulse edge=%0d got=%b want=%b", ep, press_pulse, e_prs);
    end
    vectors++;
    assert (release_pulse === e_rel) else begin
      miscompares++;
      $error("FAIL release_pulse edge=%0d got=%b want=%b", ep, release_pulse, e_rel);
    end
    vectors++;
    assert (move_pulse === e_mov) else begin
      miscompares++;
      $error("FAIL move_pulse edge=%0d got=%b want=%b", ep, move_pulse, e_mov);
    end
  endtask

  // One clock: model sees the same inputs as the DUT edge, outputs checked 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge(reset, raw_buttons);
    #1;
    check();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    int first;
    int n_prs;
    int n_rel;
    bit seen;

    reset       = 1'b1;
    raw_buttons = '1;
    run(3);
    reset = 1'b0;
    run(5);

    // Up pressed: press must land 6 edges after the first sampling edge.
    raw_buttons[0] = 1'b0;
    first = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (press_pulse[0] && first < 0) first = i;
    end
    vectors++;
    assert (first == 6) else begin
      miscompares++;
      $error("FAIL up_press_latency got=%0d want=6", first);
    end
    raw_buttons[0] = 1'b1;
    run(12);

    // Two-cycle glitch on a: nothing may move.
    seen = 1'b0;
    raw_buttons[4] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      seen |= held[4] | press_pulse[4] | release_pulse[4];
    end
    raw_buttons[4] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      seen |= held[4] | press_pulse[4] | release_pulse[4];
    end
    vectors++;
    assert (seen == 1'b0) else begin
      miscompares++;
      $error("FAIL a_glitch got=%b want=0", seen);
    end

    // Left held 40 cycles: repeats, then a single release.
    raw_buttons[2] = 1'b0;
    run(40);
    raw_buttons[2] = 1'b1;
    run(15);

    // Up and right together.
    raw_buttons[0] = 1'b0;
    raw_buttons[3] = 1'b0;
    run(25);
    raw_buttons[0] = 1'b1;
    raw_buttons[3] = 1'b1;
    run(12);

    // Down: reset during the repeat delay, button still held across reset release.
    raw_buttons[1] = 1'b0;
    first = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (press_pulse[1]) begin
        first = i;
        break;
      end
    end
    vectors++;
    assert (first >= 0) else begin
      miscompares++;
      $error("FAIL down_press_timeout got=%0d want>=0", first);
    end
    run(6);
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    first = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (press_pulse[1] && first < 0) first = i;
    end
    vectors++;
    assert (first == 6) else begin
      miscompares++;
      $error("FAIL down_after_reset got=%0d want=6", first);
    end
    raw_buttons[1] = 1'b1;
    run(12);

    // Start held 30 cycles: exactly one press and one release, no repeat.
    n_prs = 0;
    n_rel = 0;
    raw_buttons[6] = 1'b0;
    for (int i = 0; i < 42; i++) begin
      if (i == 30) raw_buttons[6] = 1'b1;
      step();
      n_prs += int'(press_pulse[6]);
      n_rel += int'(release_pulse[6]);
    end
    vectors++;
    assert (n_prs == 1 && n_rel == 1) else begin
      miscompares++;
      $error("FAIL start_pulses got=%0d/%0d want=1/1", n_prs, n_rel);
    end

    // Random pin activity: a glitchy phase, then a phase of longer holds, rare resets.
    for (int c = 0; c < 900; c++) begin
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(0, (c < 400) ? 5 : 23) == 0) raw_buttons[b] = ~raw_buttons[b];
      end
      reset = ($urandom_range(0, 149) == 0);
      step();
    end
    reset       = 1'b0;
    raw_buttons = '1;
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500_000: consecutive stable cycles required to accept a level change.
REQ-002 Parameter REPEAT_DELAY, default 25_000_000: cycles from accepted press to first auto-repeat pulse.
REQ-003 Parameter REPEAT_RATE, default 6_250_000: cycles between subsequent auto-repeat pulses.
REQ-004 Parameter ACTIVE_LOW, default 1: raw inputs read 0 when pressed.
REQ-005 clk  in  1  single system clock; the block SHALL use one clock only.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 raw_buttons  in  7  raw pins {start, b, a, right, left, down, up}, bit 0 = up.
REQ-008 held  out  7  debounced level, 1 = pressed, same bit order.
REQ-009 press_pulse  out  7  one-cycle pulse on each accepted press.
REQ-010 release_pulse  out  7  one-cycle pulse on each accepted release.
REQ-011 move_pulse  out  4  direction events for bits 0..3: press_pulse OR auto-repeat pulse.

Function
REQ-012 Each raw bit SHALL pass through a 2-flop synchroniser, then be normalised to pressed = 1 per ACTIVE_LOW.
REQ-013 Per button, a counter SHALL increment each cycle the synchronised level differs from held and SHALL clear to 0 when they match.
REQ-014 When the counter reaches DEBOUNCE_CYCLES-1 while still differing, held SHALL toggle on that edge and the counter SHALL clear.
REQ-015 A clean raw transition SHALL change held, and fire the matching pulse, exactly DEBOUNCE_CYCLES+2 edges after the first edge that samples the new raw level.
REQ-016 Glitches shorter than DEBOUNCE_CYCLES synchronised cycles SHALL produce no change and no pulse.
REQ-017 press_pulse[i] SHALL be high in exactly the cycle after held[i] rises 0->1; release_pulse[i] likewise for 1->0.
REQ-018 Each direction bit SHALL run an FSM with states IDLE, DELAY and REPEAT.
REQ-019 IDLE->DELAY on press_pulse, repeat counter loaded 0.
REQ-020 DELAY->REPEAT when the counter reaches REPEAT_DELAY-1, emitting one repeat pulse.
REQ-021 In REPEAT, one pulse SHALL be emitted every REPEAT_RATE cycles.
REQ-022 Any state ->IDLE in the cycle held drops; no repeat pulse in that cycle.
REQ-023 Directions SHALL be independent; simultaneous presses SHALL yield simultaneous pulses with no priority or masking.
REQ-024 Counters SHALL be width $clog2(max(param,2)) and SHALL saturate, never wrap.
REQ-025 Bits 4..6 (a, b, start) SHALL have no auto-repeat.

Reset
REQ-026 While reset is high: sync flops, held, all counters and all pulse outputs SHALL be 0, and all FSMs SHALL be IDLE.
REQ-027 A button held through reset release SHALL be accepted as a fresh press per REQ-015.
REQ-028 Reset asserted mid-debounce or mid-repeat SHALL abort with no pulse in the reset cycle.

Structure
REQ-029 A shared package SHALL hold the button index constants (BTN_UP=0 .. BTN_START=6), NUM_BUTTONS=7, NUM_DIRS=4 and the repeat FSM state enum.
REQ-030 Sub-module debounce_cell SHALL be used: one instance per button, containing synchroniser, counter, held and both edge pulses; repeat FSMs SHALL live in the top.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, ACTIVE_LOW=1)
REQ-031 raw up falls to 0 at edge 0 and stays low -> held[0]=1 and press_pulse[0] high for one cycle at edge 6; move_pulse[0] at edge 6.
REQ-032 raw a pulses low for 2 cycles, then high -> held, press_pulse and release_pulse remain 0 throughout.
REQ-033 left held 40 cycles -> move_pulse[2] at press edge P, P+10, P+13, P+16, ...; stops within 1 cycle of held[2] falling, release_pulse[2] one pulse.
REQ-034 up and right pressed on the same edge -> press_pulse[0] and press_pulse[3] on the same cycle; repeats aligned.
REQ-035 reset asserted at DELAY count 5 with down still held -> all outputs 0; after release, press_pulse[1] exactly 6 edges later.
REQ-036 start held 30 cycles -> single press_pulse[6], no repeats, single release_pulse[6].
